// File: rtl/seg7_flag_scanner.sv
// ---------------------------------------------------------------------------
// seg7_flag_scanner
//   Multiplexed 4-digit common-anode 7-segment driver that shows a snapshot
//   of an ALU result and its flags.
//
//   Digit scan order (one window of REFRESH_DIV clocks each):
//     idx0 : hex of snap_result[3:0]
//     idx1 : hex of snap_result[7:4]
//     idx2 : blank (anode still driven)
//     idx3 : flag bars  g = zero, d = carry, a = overflow
//   The first GUARD cycles of every window drive all anodes off so the
//   previous digit's pattern cannot ghost onto the next digit.
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   load      in   1  snapshot strobe, level-sampled every clock
//   result    in   8  ALU result to display
//   zero      in   1  ALU zero flag
//   carry     in   1  ALU carry flag
//   overflow  in   1  ALU overflow flag
//   an        out  4  anode enables, active low, an[i] selects digit i
//   seg       out  7  segments {g,f,e,d,c,b,a}, active low
//
// Outputs are registered: they reflect cnt/idx/snapshot of the previous
// cycle (one cycle of latency).
// ---------------------------------------------------------------------------
module seg7_flag_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] result,
  input  logic       zero,
  input  logic       carry,
  input  logic       overflow,
  output logic [3:0] an,
  output logic [6:0] seg
);

  // Counter must hold REFRESH_DIV-1; at least one bit.
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
  localparam logic [6:0]    SEG_OFF  = 7'h7F;
  localparam logic [3:0]    AN_OFF   = 4'b1111;

  // Active-low hex digit pattern, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      4'hF:    pat = 7'h0E;
      default: pat = SEG_OFF;
    endcase
    return pat;
  endfunction

  // Flag bars: g = zero, d = carry, a = overflow; lit segment is low.
  function automatic logic [6:0] flag_bars(input logic z, input logic c,
                                           input logic v);
    return ~{z, 2'b00, c, 2'b00, v};
  endfunction

  logic [7:0]    snap_result_r;
  logic          snap_zero_r;
  logic          snap_carry_r;
  logic          snap_overflow_r;
  logic [CW-1:0] cnt_r;
  logic [1:0]    idx_r;
  logic [3:0]    an_r;
  logic [6:0]    seg_r;
  logic [3:0]    an_nxt_s;
  logic [6:0]    seg_nxt_s;
  logic [6:0]    digit_seg_s;

  // Snapshot registers: capture on every cycle load is high, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_result_r   <= 8'h00;
      snap_zero_r     <= 1'b0;
      snap_carry_r    <= 1'b0;
      snap_overflow_r <= 1'b0;
    end else if (load) begin
      snap_result_r   <= result;
      snap_zero_r     <= zero;
      snap_carry_r    <= carry;
      snap_overflow_r <= overflow;
    end else begin
      snap_result_r   <= snap_result_r;
      snap_zero_r     <= snap_zero_r;
      snap_carry_r    <= snap_carry_r;
      snap_overflow_r <= snap_overflow_r;
    end
  end

  // Window counter and digit index; load never disturbs the scan timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
      idx_r <= 2'd0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= {CW{1'b0}};
      idx_r <= idx_r + 2'd1;
    end else begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      idx_r <= idx_r;
    end
  end

  // Segment pattern for the digit currently selected.
  always_comb begin
    digit_seg_s = SEG_OFF;
    case (idx_r)
      2'd0:    digit_seg_s = hex_to_seg(snap_result_r[3:0]);
      2'd1:    digit_seg_s = hex_to_seg(snap_result_r[7:4]);
      2'd2:    digit_seg_s = SEG_OFF;
      2'd3:    digit_seg_s = flag_bars(snap_zero_r, snap_carry_r,
                                       snap_overflow_r);
      default: digit_seg_s = SEG_OFF;
    endcase
  end

  // Next output: guard blanking at the start of each window, else digit.
  always_comb begin
    an_nxt_s  = AN_OFF;
    seg_nxt_s = SEG_OFF;
    if (cnt_r < GUARD_C) begin
      an_nxt_s  = AN_OFF;
      seg_nxt_s = SEG_OFF;
    end else begin
      an_nxt_s  = ~(4'b0001 << idx_r);
      seg_nxt_s = digit_seg_s;
    end
  end

  // Output registers; async reset blanks the display immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_r  <= AN_OFF;
      seg_r <= SEG_OFF;
    end else begin
      an_r  <= an_nxt_s;
      seg_r <= seg_nxt_s;
    end
  end

  assign an  = an_r;
  assign seg = seg_r;

  seg7_flag_scanner_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .an    (an_r),
    .seg   (seg_r)
  );

endmodule

// ---------------------------------------------------------------------------
// seg7_flag_scanner_chk
//   Property checker for the scanner outputs.
// Ports
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset
//   an     in  4  anode enables (active low)
//   seg    in  7  segments (active low)
// ---------------------------------------------------------------------------
module seg7_flag_scanner_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [3:0] an,
  input logic [6:0] seg
);

  // Never more than one anode driven at a time.
  a_one_anode: assert property (@(posedge clk) disable iff (!rst_n)
    $countones(~an) <= 1);

  // With all anodes off the segment lines are idle as well.
  a_blank_idle: assert property (@(posedge clk) disable iff (!rst_n)
    (an == 4'b1111) |-> (seg == 7'h7F));

endmodule

// File: tb/tb_seg7_flag_scanner.sv
// Directed bench for seg7_flag_scanner with REFRESH_DIV=8, GUARD=2.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_seg7_flag_scanner;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [7:0] result;
  logic       zero;
  logic       carry;
  logic       overflow;
  logic [3:0] an;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;

  seg7_flag_scanner #(.REFRESH_DIV(8), .GUARD(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow),
    .an       (an),
    .seg      (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one rising edge, then sample at the following falling edge
  task automatic cyc();
    @(negedge clk);
  endtask

  // 8-cycle window: 2 guard cycles blank, then 6 cycles of exp_an/exp_seg.
  // load is dropped after the first edge of the window.
  task automatic window(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i == 0) load = 1'b0;
      if (i < 2) begin
        chk({tag, "_guard_an"}, {3'b000, an}, 7'h0F);
        chk({tag, "_guard_seg"}, seg, 7'h7F);
      end else begin
        chk({tag, "_an"}, {3'b000, an}, {3'b000, exp_an});
        chk({tag, "_seg"}, seg, exp_seg);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; result = 8'h00;
    zero = 1'b0; carry = 1'b0; overflow = 1'b0;
    repeat (3) cyc();
    chk("reset_an", {3'b000, an}, 7'h0F);
    chk("reset_seg", seg, 7'h7F);

    // release: idx0 with empty snapshot shows "0"
    rst_n = 1'b1;
    window("w0_idx0_zero", 4'hE, 7'h40);

    // capture A5 with zero=1 carry=1 overflow=0 at the first edge of idx1
    result = 8'hA5; zero = 1'b1; carry = 1'b1; overflow = 1'b0; load = 1'b1;
    window("w1_idx1_A", 4'hD, 7'h08);
    window("w2_idx2_blank", 4'hB, 7'h7F);
    window("w3_idx3_flags_zc", 4'h7, 7'h37);
    window("w4_idx0_5", 4'hE, 7'h12);
    window("w5_idx1_A", 4'hD, 7'h08);

    // all three flags set
    overflow = 1'b1; load = 1'b1;
    window("w6_idx2_blank", 4'hB, 7'h7F);
    window("w7_idx3_flags_zcv", 4'h7, 7'h36);

    // idx0 window with a capture of 3C at cnt=5
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i < 2) chk("w8_guard_seg", seg, 7'h7F);
      else begin
        chk("w8_pre_an", {3'b000, an}, 7'h0E);
        chk("w8_pre_seg", seg, 7'h12);
      end
    end
    result = 8'h3C; load = 1'b1;
    cyc();
    load = 1'b0;
    chk("w8_capture_edge_seg", seg, 7'h12);
    cyc();
    chk("w8_post_an", {3'b000, an}, 7'h0E);
    chk("w8_post_seg", seg, 7'h46);
    cyc();
    chk("w8_last_seg", seg, 7'h46);
    // digit switch still at the counter wrap
    window("w9_idx1_3", 4'hD, 7'h30);
    window("w10_idx2_blank", 4'hB, 7'h7F);

    // async reset in the middle of idx3
    for (int i = 0; i < 4; i++) cyc();
    chk("w11_pre_an", {3'b000, an}, 7'h07);
    chk("w11_pre_seg", seg, 7'h36);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an", {3'b000, an}, 7'h0F);
    chk("async_rst_seg", seg, 7'h7F);
    repeat (2) cyc();
    rst_n = 1'b1;
    window("w12_idx0_after_rst", 4'hE, 7'h40);
    window("w13_idx1_after_rst", 4'hD, 7'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
